// File: rtl/seg_pattern_capture.sv
// Debounces an active-low 7-segment input bus, decodes stable patterns back to BCD,
// and shifts accepted digits into a multi-digit BCD operand register.
module seg_pattern_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [6:0]                        seg_n,
  input  logic                              clr,
  output logic                              digit_valid,
  output logic [3:0]                        digit,
  output logic                              code_err,
  output logic [4*NUM_DIGITS-1:0]           value,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              overflow
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int CW    = $clog2(NUM_DIGITS + 1);
  localparam int VW    = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
  localparam logic [CW-1:0]    COUNT_MAX = CW'(NUM_DIGITS);
  localparam logic [6:0]       BLANK     = 7'h7F;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_EVAL = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  // Returns {is_digit, bcd}; non-digit patterns (including blank) give is_digit=0.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]       seg_q, seg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [6:0]       last_acc_q, last_acc_d;
  logic             digit_valid_q, digit_valid_d;
  logic             code_err_q, code_err_d;
  logic [3:0]       digit_q, digit_d;
  logic [VW-1:0]    value_q, value_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             seg_chg;
  logic             accept;
  logic [4:0]       dec;
  logic [VW-1:0]    dig_ext;

  // Next-state logic: debounce counter, decision FSM and operand register.
  always_comb begin
    seg_d         = seg_n;
    cnt_d         = cnt_q;
    state_d       = state_q;
    last_acc_d    = last_acc_q;
    digit_valid_d = 1'b0;
    code_err_d    = 1'b0;
    digit_d       = digit_q;
    value_d       = value_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    accept        = 1'b0;
    dec           = decode_seg(seg_q);
    dig_ext       = '0;
    dig_ext[3:0]  = dec[3:0];

    seg_chg = (seg_n != seg_q);
    if (seg_chg) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_WAIT: state_d = (cnt_d == CNT_MAX) ? ST_EVAL : ST_WAIT;
      ST_EVAL: state_d = ST_HELD;
      ST_HELD: state_d = ST_HELD;
      default: state_d = ST_WAIT;
    endcase
    if (seg_chg) begin
      state_d = (cnt_d == CNT_MAX) ? ST_EVAL : ST_WAIT;
    end else begin
      state_d = state_d;
    end

    // Single decision edge; a return to the last accepted pattern is treated as bounce.
    if (state_q == ST_EVAL) begin
      if (seg_q == BLANK) begin
        last_acc_d = BLANK;
      end else if (seg_q == last_acc_q) begin
        last_acc_d = last_acc_q;
      end else if (dec[4]) begin
        accept        = 1'b1;
        digit_valid_d = 1'b1;
        digit_d       = dec[3:0];
        last_acc_d    = seg_q;
      end else begin
        code_err_d = 1'b1;
        digit_d    = 4'hF;
      end
    end else begin
      accept = 1'b0;
    end

    if (clr) begin
      value_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (accept) begin
      if (count_q < COUNT_MAX) begin
        value_d = (value_q << 4) | dig_ext;
        count_d = count_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      value_d = value_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q         <= BLANK;
      cnt_q         <= '0;
      state_q       <= ST_WAIT;
      last_acc_q    <= BLANK;
      digit_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      digit_q       <= 4'h0;
      value_q       <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      last_acc_q    <= last_acc_d;
      digit_valid_q <= digit_valid_d;
      code_err_q    <= code_err_d;
      digit_q       <= digit_d;
      value_q       <= value_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign digit_valid = digit_valid_q;
  assign code_err    = code_err_q;
  assign digit       = digit_q;
  assign value       = value_q;
  assign digit_count = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seg_pattern_capture.sv
// Directed bench for seg_pattern_capture (STABLE_CYCLES=4, NUM_DIGITS=4).
module tb_seg_pattern_capture;

  logic        clk;
  logic        reset;
  logic [6:0]  seg_n;
  logic        clr;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        code_err;
  logic [15:0] value;
  logic [2:0]  digit_count;
  logic        overflow;

  int n_tests  = 0;
  int n_failed = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int base_v;
  int base_e;

  seg_pattern_capture #(.STABLE_CYCLES(4), .NUM_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .clr(clr),
    .digit_valid(digit_valid), .digit(digit), .code_err(code_err),
    .value(value), .digit_count(digit_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (digit_valid) n_valid = n_valid + 1;
    if (code_err)    n_err   = n_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_failed = n_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_n = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr   = 1'b0;
    seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, digit_valid}, 32'd0);
    check("rst_digit", {28'd0, digit}, 32'd0);
    check("rst_value", {16'd0, value}, 32'd0);
    check("rst_count", {29'd0, digit_count}, 32'd0);
    check("rst_ovf",   {31'd0, overflow}, 32'd0);
    reset = 1'b0;

    // 1: single digit 3
    base_v = n_valid;
    hold(7'h30, 10);
    check("t1_pulses", n_valid - base_v, 32'd1);
    check("t1_digit", {28'd0, digit}, 32'd3);
    check("t1_value", {16'd0, value}, 32'h0003);
    check("t1_count", {29'd0, digit_count}, 32'd1);

    // 2: fill register, then overflow
    pulse_clr();
    hold(7'h79, 6); hold(7'h7F, 6); hold(7'h24, 6); hold(7'h7F, 6);
    hold(7'h30, 6); hold(7'h7F, 6); hold(7'h19, 6);
    check("t2_value", {16'd0, value}, 32'h1234);
    check("t2_count", {29'd0, digit_count}, 32'd4);
    check("t2_ovf0", {31'd0, overflow}, 32'd0);
    base_v = n_valid;
    hold(7'h7F, 6); hold(7'h12, 6);
    check("t2_ovf_pulse", n_valid - base_v, 32'd1);
    check("t2_ovf_digit", {28'd0, digit}, 32'd5);
    check("t2_ovf_value", {16'd0, value}, 32'h1234);
    check("t2_ovf1", {31'd0, overflow}, 32'd1);

    // 3: too-short pattern is ignored
    hold(7'h7F, 6);
    base_v = n_valid;
    hold(7'h79, 3); hold(7'h7F, 6);
    check("t3_pulses", n_valid - base_v, 32'd0);
    check("t3_value", {16'd0, value}, 32'h1234);

    // 4: glitch back to the same digit is one pulse
    pulse_clr();
    hold(7'h7F, 6);
    base_v = n_valid;
    hold(7'h12, 6); hold(7'h00, 1); hold(7'h12, 8);
    check("t4_pulses", n_valid - base_v, 32'd1);
    check("t4_value", {16'd0, value}, 32'h0005);

    // 5: same digit after an intervening blank
    hold(7'h7F, 6); hold(7'h12, 6);
    check("t5_pulses", n_valid - base_v, 32'd2);
    check("t5_value", {16'd0, value}, 32'h0055);
    check("t5_count", {29'd0, digit_count}, 32'd2);

    // 6a: invalid pattern
    hold(7'h7F, 6);
    base_v = n_valid;
    base_e = n_err;
    hold(7'h55, 8);
    check("t6_err", n_err - base_e, 32'd1);
    check("t6_noval", n_valid - base_v, 32'd0);
    check("t6_digit", {28'd0, digit}, 32'hF);
    check("t6_value", {16'd0, value}, 32'h0055);

    // 6b: clr on the accept edge wins
    hold(7'h7F, 6);
    base_v = n_valid;
    hold(7'h19, 4);
    pulse_clr();
    hold(7'h19, 2);
    check("t6_clr_pulse", n_valid - base_v, 32'd1);
    check("t6_clr_digit", {28'd0, digit}, 32'd4);
    check("t6_clr_value", {16'd0, value}, 32'd0);
    check("t6_clr_count", {29'd0, digit_count}, 32'd0);
    check("t6_clr_ovf", {31'd0, overflow}, 32'd0);

    // 6c: reset mid-count discards the partial count
    hold(7'h7F, 6);
    base_v = n_valid;
    hold(7'h24, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hold(7'h24, 2);
    hold(7'h7F, 6);
    check("t6_rst_pulses", n_valid - base_v, 32'd0);
    check("t6_rst_value", {16'd0, value}, 32'd0);
    check("t6_rst_digit", {28'd0, digit}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
